// File: rtl/data_memory_responder.sv
// Data-memory responder: word-organised byte-lane RAM behind a load/store handshake
// with programmable wait states, alignment checks and load extension.

module data_memory_responder_lane #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] idx_i,
  input  logic [7:0]            wdata_i,
  output logic [7:0]            rdata_o
);
  logic [7:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  // No reset on storage: contents survive a reset of the control path.
  always_ff @(posedge clock_i)
    if (we_i) mem_q[idx_i] <= wdata_i;

  assign rdata_o = mem_q[idx_i];
endmodule

module data_memory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        read_enable_i,
  input  logic        write_enable_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  input  logic [2:0]  size_funct3_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic        misaligned_o
);
  localparam int        NUM_LANES = 4;
  localparam logic [3:0] WS4      = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH+1:0] addr;
    logic [31:0]           wdata;
    logic [2:0]            size;
  } req_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  req_t        req_q, live, cur;
  logic [31:0] read_data_q;
  logic        ready_q, misaligned_q;

  logic                          req, fire, mis;
  logic [1:0]                    off;
  logic [ADDR_WIDTH-1:0]         idx;
  logic [NUM_LANES-1:0]          be;
  logic [NUM_LANES-1:0][7:0]     rword;
  logic [31:0]                   sh, wsh, ld;

  logic unused_addr_hi;
  assign unused_addr_hi = ^address_i[31:ADDR_WIDTH+2];

  always_comb begin
    req  = read_enable_i | write_enable_i;
    live = '{wr: write_enable_i, addr: address_i[ADDR_WIDTH+1:0],
             wdata: write_data_i, size: size_funct3_i};
    // With zero wait states the access happens on the edge that sees the request.
    cur  = (state_q == S_IDLE) ? live : req_q;
    fire = ((state_q == S_IDLE) && req && (WAIT_STATES == 0)) ||
           ((state_q == S_WAIT) && req && (cnt_q == 4'd1));
    off  = cur.addr[1:0];
    idx  = cur.addr[ADDR_WIDTH+1:2];
    sh   = rword >> {off, 3'b000};
    wsh  = cur.wdata << {off, 3'b000};
    be   = '0;
    mis  = 1'b0;
    ld   = rword;
    if (cur.wr) begin
      case (cur.size)
        3'b000:  be = 4'b0001 << off;
        3'b001:  begin be = 4'b0011 << off; mis = off[0]; end
        3'b010:  begin be = 4'b1111;        mis = |off;   end
        default: mis = 1'b1;
      endcase
    end else begin
      case (cur.size)
        3'b000:  ld = {{24{sh[7]}}, sh[7:0]};
        3'b001:  begin ld = {{16{sh[15]}}, sh[15:0]}; mis = off[0]; end
        3'b100:  ld = {24'd0, sh[7:0]};
        3'b101:  begin ld = {16'd0, sh[15:0]}; mis = off[0]; end
        default: mis = |off;  // W and undefined codes behave as a word load
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    data_memory_responder_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clock_i (clock_i),
      .we_i    (fire & cur.wr & ~mis & be[g]),
      .idx_i   (idx),
      .wdata_i (wsh[g*8 +: 8]),
      .rdata_o (rword[g])
    );
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      ready_q      <= 1'b0;
      misaligned_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      ready_q      <= 1'b0;
      misaligned_q <= 1'b0;
      read_data_q  <= '0;
      if (fire) begin
        ready_q      <= 1'b1;
        misaligned_q <= mis;
        read_data_q  <= (cur.wr || mis) ? 32'd0 : ld;
      end
      case (state_q)
        S_IDLE: if (req) begin
          req_q   <= live;
          cnt_q   <= WS4;
          state_q <= fire ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          if (!req) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_data_o  = read_data_q;
  assign ready_o      = ready_q;
  assign misaligned_o = misaligned_q;
endmodule
